// File: rtl/pipo_register_if.sv
// -----------------------------------------------------------------------------
// pipo_register_if
// Bundle for the parallel-in/parallel-out holding register.
//   i_Ld      : load enable, producer -> register
//   i_Data    : WIDTH-bit word to capture, producer -> register
//   o_Data    : held word, register -> consumer
//   o_Valid   : at least one load since reset, register -> consumer
//   o_Ld_Ack  : one-cycle pulse after each capturing edge, register -> consumer
// The master modport is the side that drives the load and the data.
// The slave modport is the register itself.
// -----------------------------------------------------------------------------
interface pipo_register_if #(
    parameter int WIDTH = 8
);
    logic             i_Ld;
    logic [WIDTH-1:0] i_Data;
    logic [WIDTH-1:0] o_Data;
    logic             o_Valid;
    logic             o_Ld_Ack;

    modport master (
        output i_Ld,
        output i_Data,
        input  o_Data,
        input  o_Valid,
        input  o_Ld_Ack
    );

    modport slave (
        input  i_Ld,
        input  i_Data,
        output o_Data,
        output o_Valid,
        output o_Ld_Ack
    );
endinterface

// File: rtl/pipo_register.sv
// -----------------------------------------------------------------------------
// pipo_register
// Parallel-in/parallel-out holding register for the comm-module datapath.
// When i_Ld is high at a rising edge, the register captures i_Data. It then
// holds that word on o_Data until the next load or a reset. The register also
// provides these status outputs:
//   o_Valid  : sticky flag. It goes high on the first load after reset.
//   o_Ld_Ack : high for the cycle that follows each capturing edge.
// Ports:
//   i_Clk : system clock. All state changes on its rising edge.
//   i_Rst : asynchronous, active-high reset. Reset release must already be
//           synchronised to i_Clk.
//   bus   : pipo_register_if.slave. Carries i_Ld and i_Data in, and
//           o_Data, o_Valid and o_Ld_Ack out.
// Every output comes directly from a flop. The only path from an input to an
// output that does not go through a flop is the asynchronous reset.
// The WIDTH of the bus instance must match the WIDTH of this module.
// -----------------------------------------------------------------------------
module pipo_register #(
    parameter int          WIDTH       = 8,
    parameter logic [63:0] RESET_VALUE = 64'd0
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    pipo_register_if.slave bus
);
    // RESET_VALUE is given as 64 bits. Keep only the low WIDTH bits. This
    // zero-extends a short constant and truncates a wide one.
    localparam logic [WIDTH-1:0] RESET_WORD = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    logic             valid_reg;
    logic             valid_next;
    logic             ack_reg;
    logic             ack_next;

    // Next-state logic. Without a load, the data word and the valid flag keep
    // their values, and the acknowledge pulse clears.
    always_comb begin
        data_next  = data_reg;
        valid_next = valid_reg;
        ack_next   = 1'b0;
        if (bus.i_Ld) begin
            data_next  = bus.i_Data;
            valid_next = 1'b1;
            ack_next   = 1'b1;
        end
    end

    // Reset takes priority over a load on the same edge. A word captured before
    // the reset is lost.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            data_reg  <= RESET_WORD;
            valid_reg <= 1'b0;
            ack_reg   <= 1'b0;
        end else begin
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ack_reg   <= ack_next;
        end
    end

    assign bus.o_Data   = data_reg;
    assign bus.o_Valid  = valid_reg;
    assign bus.o_Ld_Ack = ack_reg;
endmodule

// File: tb/tb_pipo_register.sv
module tb_pipo_register;
    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    pipo_register_if #(.WIDTH(8)) bus ();
    pipo_register_if #(.WIDTH(4)) bus4 ();

    // The 4-bit instance receives the low nibble of the same stimulus. Its
    // reset value is 9 bits wide, so it checks truncation.
    assign bus4.i_Ld   = bus.i_Ld;
    assign bus4.i_Data = bus.i_Data[3:0];

    pipo_register #(.WIDTH(8), .RESET_VALUE(64'd0)) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    pipo_register #(.WIDTH(4), .RESET_VALUE(64'h1A5)) dut4 (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model. It records the last captured word, the number of loads
    // since reset, and the edge index of the most recent capture.
    logic [7:0] m_word;
    logic [3:0] m_word4;
    int         m_loads;
    int         m_cycle;
    int         m_last_load;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [7:0] data;
        logic [7:0] e_data;
        logic       e_valid;
        logic       e_ack;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_word      = 8'h00;
        m_word4     = 4'h5;
        m_loads     = 0;
        m_last_load = -1;
    endtask

    task automatic model_edge(input logic r, input logic ld, input logic [7:0] d);
        m_cycle++;
        if (r) begin
            model_reset();
        end else if (ld) begin
            m_word      = d;
            m_word4     = d[3:0];
            m_loads     = m_loads + 1;
            m_last_load = m_cycle;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".data"},  {56'd0, bus.o_Data},    {56'd0, m_word});
        check({tag, ".valid"}, {63'd0, bus.o_Valid},   {63'd0, (m_loads > 0)});
        check({tag, ".ack"},   {63'd0, bus.o_Ld_Ack},  {63'd0, (m_last_load == m_cycle)});
        check({tag, ".data4"}, {60'd0, bus4.o_Data},   {60'd0, m_word4});
    endtask

    // Set the inputs away from the rising edge, let one edge pass, then sample.
    task automatic apply(input logic r, input logic ld, input logic [7:0] d);
        @(negedge clk);
        rst        = r;
        bus.i_Ld   = ld;
        bus.i_Data = d;
        @(posedge clk);
        #1;
        model_edge(r, ld, d);
    endtask

    initial begin
        m_cycle = 0;
        model_reset();

        // Fields: rst, ld, data -> expected data, valid, ack
        vecs[0]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'hAC, 8'hAC, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 8'hAA, 8'hAC, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'hAA, 8'hAC, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 8'hAA, 8'hAC, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'hAA, 8'hAA, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 8'h33, 8'hAA, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h01, 8'h01, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 8'h02, 8'h02, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 8'h03, 8'h03, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 8'h04, 8'h04, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 8'h80, 8'h04, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 8'h77, 8'h00, 1'b0, 1'b0};

        // Assert reset at time zero. The outputs must respond before any
        // clock edge.
        rst        = 1'b1;
        bus.i_Ld   = 1'b1;
        bus.i_Data = 8'hFF;
        #1;
        check("async_rst.data",  {56'd0, bus.o_Data},   64'h00);
        check("async_rst.valid", {63'd0, bus.o_Valid},  64'd0);
        check("async_rst.ack",   {63'd0, bus.o_Ld_Ack}, 64'd0);
        check("async_rst.data4", {60'd0, bus4.o_Data},  64'h5);

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].rst, vecs[i].ld, vecs[i].data);
            check($sformatf("vec%0d.data", i),  {56'd0, bus.o_Data},   {56'd0, vecs[i].e_data});
            check($sformatf("vec%0d.valid", i), {63'd0, bus.o_Valid},  {63'd0, vecs[i].e_valid});
            check($sformatf("vec%0d.ack", i),   {63'd0, bus.o_Ld_Ack}, {63'd0, vecs[i].e_ack});
            $display("vec %0d: rst=%0b ld=%0b din=%02h -> dout=%02h valid=%0b ack=%0b",
                     i, vecs[i].rst, vecs[i].ld, vecs[i].data, bus.o_Data, bus.o_Valid, bus.o_Ld_Ack);
        end

        // Load a word, then pulse reset between two clock edges.
        apply(1'b0, 1'b1, 8'hAA);
        check("pre_pulse.data", {56'd0, bus.o_Data}, 64'hAA);
        @(negedge clk);
        bus.i_Ld = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst.data",  {56'd0, bus.o_Data},   64'h00);
        check("mid_rst.valid", {63'd0, bus.o_Valid},  64'd0);
        check("mid_rst.ack",   {63'd0, bus.o_Ld_Ack}, 64'd0);
        check("mid_rst.data4", {60'd0, bus4.o_Data},  64'h5);
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        model_edge(1'b0, 1'b0, bus.i_Data);
        check_model("post_pulse_hold");
        apply(1'b0, 1'b1, 8'h5A);
        check("reload.data",  {56'd0, bus.o_Data},   64'h5A);
        check("reload.valid", {63'd0, bus.o_Valid},  64'd1);
        check("reload.ack",   {63'd0, bus.o_Ld_Ack}, 64'd1);
        $display("async pulse: dout=%02h valid=%0b after reload", bus.o_Data, bus.o_Valid);

        // Apply random traffic with occasional synchronous-edge resets.
        for (int i = 0; i < 300; i++) begin
            logic       r;
            logic       ld;
            logic [7:0] d;
            r  = ($urandom_range(0, 19) == 0);
            ld = $urandom_range(0, 1) == 1;
            d  = 8'($urandom);
            apply(r, ld, d);
            check_model($sformatf("rnd%0d", i));
            $display("rnd %0d: rst=%0b ld=%0b din=%02h -> dout=%02h valid=%0b ack=%0b",
                     i, r, ld, d, bus.o_Data, bus.o_Valid, bus.o_Ld_Ack);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipo_register.md
Name: pipo_register

Overview:
- Parallel-in/parallel-out holding register in the comm-module FPGA datapath, next to the nRF interface logic.
- Captures a full data word on a clock edge when load is asserted.
- Holds that word on its output until the next load or a reset.
- Also provides a loaded-since-reset flag and a one-cycle load-acknowledge pulse for downstream handshaking.

Parameters:
- WIDTH, 8, data word width in bits (legal range 1..64).
- RESET_VALUE, 0, value o_Data takes during and after reset (WIDTH bits, zero-extended or truncated to WIDTH).

Ports:
- i_Clk  input  1  single system clock; all state updates on its rising edge.
- i_Rst  input  1  asynchronous, active-high reset.
- i_Ld  input  1  load enable; when high at a rising edge, i_Data is captured.
- i_Data  input  WIDTH  parallel data word to capture.
- o_Data  output  WIDTH  registered data word; always driven directly from a flop.
- o_Valid  output  1  high once at least one load has completed since the last reset.
- o_Ld_Ack  output  1  one-cycle pulse, high in the cycle after a capturing edge.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - i_Rst asserted drives o_Data=RESET_VALUE, o_Valid=0, o_Ld_Ack=0 immediately, with no clock required.
  - Outputs hold those values while i_Rst stays high. i_Ld is ignored during reset.
  - Reset release is synchronised externally; the block does not resynchronise it.
- Load:
  - At a rising edge with i_Rst=0 and i_Ld=1: o_Data <= i_Data, o_Valid <= 1, o_Ld_Ack <= 1.
  - Latency is one clock: the new value appears on o_Data after the capturing edge.
- Hold:
  - At a rising edge with i_Ld=0: o_Data and o_Valid unchanged, o_Ld_Ack <= 0.
  - i_Data changes while i_Ld=0 never reach o_Data.
- Continuous load:
  - i_Ld held high across N edges captures i_Data at every edge.
  - o_Ld_Ack stays high for those N cycles (one pulse per capture, contiguous).
- o_Valid:
  - Sticky; clears only on reset.
  - Once set, unaffected by i_Ld or i_Data.
- Reset mid-operation:
  - Reset asserted in the same cycle as i_Ld=1: reset wins, and nothing is captured.
  - Reset asserted between edges: outputs go to reset values immediately and the previously held word is discarded.
- No combinational path from any input to any output, other than the asynchronous reset path.
- Width: o_Data bit k always corresponds to i_Data bit k. No reordering, no sign handling.

Test Plan:
- Reset: assert i_Rst with i_Data=8'hFF, i_Ld=1 over several edges -> o_Data=8'h00, o_Valid=0, o_Ld_Ack=0 throughout.
- Basic load (20 ns clock): release reset, i_Data=8'hAC, i_Ld=1 for one edge -> o_Data=8'hAC after that edge, o_Valid=1, o_Ld_Ack high exactly one cycle.
- Hold: after 8'hAC is loaded, i_Ld=0, change i_Data to 8'hAA and wait 3 edges -> o_Data stays 8'hAC, o_Ld_Ack=0.
- Reload: raise i_Ld=1 with i_Data=8'hAA -> o_Data=8'hAA after the next edge, o_Valid stays 1.
- Continuous load: i_Ld=1 for 4 edges with i_Data stepping 8'h01,8'h02,8'h03,8'h04 -> o_Data follows one cycle late, ending at 8'h04, o_Ld_Ack high for 4 cycles.
- Asynchronous reset mid-hold: with o_Data=8'hAA, pulse i_Rst between clock edges -> o_Data=8'h00 and o_Valid=0 before the next edge; a later load of 8'h5A then gives o_Data=8'h5A.
